d3s_lut_loader: RTL and testbench

D3S_LUT_LOADER -- requirements
Module: d3s_lut_loader

---
 rtl/d3s_lut_loader.sv | 164 ++++++++++++++++
 tb/tb_d3s_lut_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/d3s_lut_loader.sv
// Shadow-bank LUT reloader: clears both tables of the shadow bank, accepts host
// writes, then swaps the active bank at the next safe point in the phase stream.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | no reload in progress; waiting for load_start_i
// ST_CLEAR     | zeroing lut01 then lut23 of the shadow bank, one entry/cycle
// ST_LOAD      | host writes accepted into the shadow bank
// ST_SWAP_WAIT | reload committed; waiting for swap_sync_i to flip banks
module d3s_lut_loader #(
    parameter int g_lut_size_log2 = 10,
    parameter int g_entry_bits    = 36
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       load_start_i,
    input  logic                       load_commit_i,
    input  logic                       load_abort_i,
    input  logic                       swap_sync_i,
    input  logic                       host_wr_i,
    input  logic                       host_sel_i,
    input  logic [g_lut_size_log2-1:0] host_addr_i,
    input  logic [g_entry_bits-1:0]    host_data_i,
    output logic                       host_ready_o,
    output logic                       lut_we_o,
    output logic                       lut_bank_o,
    output logic                       lut_sel_o,
    output logic [g_lut_size_log2-1:0] lut_addr_o,
    output logic [g_entry_bits-1:0]    lut_data_o,
    output logic                       active_bank_o,
    output logic                       busy_o,
    output logic                       done_p_o,
    output logic                       err_o
);

    // Counter MSB selects the table, so the final clear index is all ones.
    localparam int CW = g_lut_size_log2 + 1;
    localparam logic [CW-1:0] CLR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SWAP_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              clr_cnt_q, clr_cnt_d;
    logic                       active_q, active_d;
    logic                       bank_q, bank_d;
    logic                       we_q, we_d;
    logic                       sel_q, sel_d;
    logic [g_lut_size_log2-1:0] addr_q, addr_d;
    logic [g_entry_bits-1:0]    data_q, data_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       ready;
    logic                       illegal_wr;

    assign ready      = (state_q == ST_LOAD);
    assign illegal_wr = host_wr_i & ~ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        active_d  = active_q;
        we_d      = 1'b0;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = err_q | illegal_wr;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    err_d     = illegal_wr;
                end
            end
            ST_CLEAR: begin
                if (load_abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d      = 1'b1;
                    sel_d     = clr_cnt_q[CW-1];
                    addr_d    = clr_cnt_q[g_lut_size_log2-1:0];
                    data_d    = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (load_abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (host_wr_i) begin
                        we_d   = 1'b1;
                        sel_d  = host_sel_i;
                        addr_d = host_addr_i;
                        data_d = host_data_i;
                    end
                    // A swap_sync_i coinciding with the commit is deliberately not seen here.
                    if (load_commit_i) begin
                        state_d = ST_SWAP_WAIT;
                    end
                end
            end
            ST_SWAP_WAIT: begin
                if (load_abort_i) begin
                    state_d = ST_IDLE;
                end else if (swap_sync_i) begin
                    active_d = ~active_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bank_d = ~active_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            active_q  <= 1'b0;
            bank_q    <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            active_q  <= active_d;
            bank_q    <= bank_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign host_ready_o  = ready;
    assign lut_we_o      = we_q;
    assign lut_bank_o    = bank_q;
    assign lut_sel_o     = sel_q;
    assign lut_addr_o    = addr_q;
    assign lut_data_o    = data_q;
    assign active_bank_o = active_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_p_o      = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_d3s_lut_loader.sv
// Directed bench for d3s_lut_loader: table of LOAD-phase host writes plus
// hand sequences for clear, commit/swap, error flag and abort.
module tb_d3s_lut_loader;

    localparam int L = 10;
    localparam int E = 36;
    localparam int N = 1 << L;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start, load_commit, load_abort, swap_sync;
    logic         host_wr, host_sel;
    logic [L-1:0] host_addr;
    logic [E-1:0] host_data;
    logic         host_ready, lut_we, lut_bank, lut_sel;
    logic [L-1:0] lut_addr;
    logic [E-1:0] lut_data;
    logic         active_bank, busy, done_p, err;

    int n_cmp = 0;
    int n_err = 0;

    d3s_lut_loader #(.g_lut_size_log2(L), .g_entry_bits(E)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .load_start_i  (load_start),
        .load_commit_i (load_commit),
        .load_abort_i  (load_abort),
        .swap_sync_i   (swap_sync),
        .host_wr_i     (host_wr),
        .host_sel_i    (host_sel),
        .host_addr_i   (host_addr),
        .host_data_i   (host_data),
        .host_ready_o  (host_ready),
        .lut_we_o      (lut_we),
        .lut_bank_o    (lut_bank),
        .lut_sel_o     (lut_sel),
        .lut_addr_o    (lut_addr),
        .lut_data_o    (lut_data),
        .active_bank_o (active_bank),
        .busy_o        (busy),
        .done_p_o      (done_p),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         sel;
        logic [L-1:0] addr;
        logic [E-1:0] data;
        logic         exp_we;
        logic         exp_sel;
        logic [L-1:0] exp_addr;
        logic [E-1:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input logic exp_bank);
        int k;
        int bad;
        int cyc;
        k = 0;
        bad = 0;
        cyc = 0;
        while (cyc < 3000) begin
            step();
            cyc++;
            if (lut_we) begin
                if (lut_data !== '0 || lut_bank !== exp_bank ||
                    lut_sel !== ((k >= N) ? 1'b1 : 1'b0) || int'(lut_addr) != (k % N))
                    bad++;
                k++;
            end
            if (host_ready) break;
        end
        chk("clear_timeout", (cyc >= 3000) ? 64'd1 : 64'd0, 64'd0);
        chk("clear_write_count", 64'(k), 64'd2048);
        chk("clear_bad_writes", 64'(bad), 64'd0);
        chk("clear_busy", 64'(busy), 64'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int seen;
        vecs[0] = '{1'b1, 1'b1, 10'h155, 36'h123456789, 1'b1, 1'b1, 10'h155, 36'h123456789};
        vecs[1] = '{1'b1, 1'b0, 10'h000, 36'hFFFFFFFFF, 1'b1, 1'b0, 10'h000, 36'hFFFFFFFFF};
        vecs[2] = '{1'b1, 1'b0, 10'h3FF, 36'h000000001, 1'b1, 1'b0, 10'h3FF, 36'h000000001};
        vecs[3] = '{1'b0, 1'b1, 10'h111, 36'h0DEADBEEF, 1'b0, 1'b0, 10'h3FF, 36'h000000001};
        vecs[4] = '{1'b1, 1'b1, 10'h3FF, 36'hA5A5A5A5A, 1'b1, 1'b1, 10'h3FF, 36'hA5A5A5A5A};

        rst_n = 1'b0;
        load_start = 0; load_commit = 0; load_abort = 0; swap_sync = 0;
        host_wr = 0; host_sel = 0; host_addr = '0; host_data = '0;
        #22;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(host_ready), 64'd0);
        chk("rst_we", 64'(lut_we), 64'd0);
        chk("rst_bank", 64'(lut_bank), 64'd0);
        chk("rst_active", 64'(active_bank), 64'd0);
        chk("rst_outs", {lut_sel, lut_addr, lut_data, done_p, err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("bank_after_reset", 64'(lut_bank), 64'd1);

        // Illegal write in IDLE, then a clean load_start clears the flag.
        host_wr = 1; host_addr = 10'h0AA;
        step();
        host_wr = 0;
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_we", 64'(lut_we), 64'd0);
        load_start = 1;
        step();
        load_start = 0;
        chk("err_cleared", 64'(err), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        run_clear(1'b1);

        for (int i = 0; i < 5; i++) begin
            host_wr = vecs[i].wr; host_sel = vecs[i].sel;
            host_addr = vecs[i].addr; host_data = vecs[i].data;
            step();
            host_wr = 0;
            chk($sformatf("vec%0d_we", i), 64'(lut_we), 64'(vecs[i].exp_we));
            chk($sformatf("vec%0d_sel", i), 64'(lut_sel), 64'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_addr", i), 64'(lut_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_data", i), 64'(lut_data), 64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_bank", i), 64'(lut_bank), 64'd1);
        end

        // Commit with a write in the same cycle; swap_sync 10 cycles later.
        load_commit = 1; host_wr = 1; host_sel = 0; host_addr = 10'h2AA; host_data = 36'h00000BEEF;
        step();
        load_commit = 0; host_wr = 0;
        chk("commit_wr_we", 64'(lut_we), 64'd1);
        chk("commit_wr_addr", 64'(lut_addr), 64'h2AA);
        chk("commit_wr_data", 64'(lut_data), 64'hBEEF);
        chk("swapwait_ready", 64'(host_ready), 64'd0);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (lut_we || done_p || active_bank) seen++;
        end
        chk("swapwait_quiet", 64'(seen), 64'd0);
        swap_sync = 1;
        step();
        swap_sync = 0;
        chk("swap_active", 64'(active_bank), 64'd1);
        chk("swap_done", 64'(done_p), 64'd1);
        chk("swap_bank", 64'(lut_bank), 64'd0);
        step();
        chk("done_pulse_end", 64'(done_p), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Commit and swap_sync together: swap deferred to the next sync.
        load_start = 1;
        step();
        load_start = 0;
        run_clear(1'b0);
        load_commit = 1; swap_sync = 1;
        step();
        load_commit = 0; swap_sync = 0;
        chk("cosync_no_swap", 64'(active_bank), 64'd1);
        chk("cosync_busy", 64'(busy), 64'd1);
        chk("cosync_no_done", 64'(done_p), 64'd0);
        step(); step();
        swap_sync = 1;
        step();
        swap_sync = 0;
        chk("cosync_late_swap", 64'(active_bank), 64'd0);
        chk("cosync_late_done", 64'(done_p), 64'd1);

        // Sync in IDLE does nothing.
        step();
        swap_sync = 1;
        step();
        swap_sync = 0;
        chk("idle_sync_active", 64'(active_bank), 64'd0);
        chk("idle_sync_done", 64'(done_p), 64'd0);

        // Illegal write coinciding with start keeps err; abort at clear count 700.
        host_wr = 1;
        step();
        load_start = 1;
        step();
        load_start = 0; host_wr = 0;
        chk("start_wr_err_kept", 64'(err), 64'd1);
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (done_p) seen++;
        end
        chk("mid_clear_busy", 64'(busy), 64'd1);
        chk("mid_clear_addr", 64'(lut_addr), 64'd699);
        load_abort = 1;
        step();
        load_abort = 0;
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_we_dropped", 64'(lut_we), 64'd0);
        chk("abort_active", 64'(active_bank), 64'd0);
        if (done_p) seen++;
        chk("abort_no_done", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
